// File: rtl/switch_conditioner.sv
// Switch debouncer: each bit is synchronized through two flops, then must disagree
// with the output for DB_CYCLES consecutive cycles before the output bit follows.

module switch_conditioner #(
    parameter int WIDTH     = 8,
    parameter int DB_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] switches,
    output logic             sw_changed,
    output logic             sw_stable
);
    localparam int            CW      = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic [WIDTH-1:0]         r_s1;
    logic [WIDTH-1:0]         r_s2;
    logic [WIDTH-1:0]         r_level;
    logic [WIDTH-1:0][CW-1:0] r_cnt;
    logic                     r_changed;

    logic [WIDTH-1:0]         w_diff;
    logic [WIDTH-1:0]         w_update;
    logic [WIDTH-1:0]         w_idle;

    always_comb begin
        w_diff   = '0;
        w_update = '0;
        w_idle   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_diff[i]   = r_s2[i] != r_level[i];
            w_update[i] = w_diff[i] && (r_cnt[i] == CNT_MAX);
            w_idle[i]   = r_cnt[i] == '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= sw_raw;
            r_s2 <= r_s1;
        end
    end

    // Any cycle where the synchronized level matches the output restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_level <= '0;
            r_cnt   <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (!w_diff[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_update[i]) begin
                    r_level[i] <= r_s2[i];
                    r_cnt[i]   <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_changed <= 1'b0;
        else      r_changed <= |w_update;
    end

    assign switches   = r_level;
    assign sw_changed = r_changed;
    assign sw_stable  = &w_idle;

endmodule

// File: tb/tb_switch_conditioner.sv
// Bench for switch_conditioner: directed scenarios plus random stimulus, all checked
// against a history-window reference model of the debounce rules.

module tb_switch_conditioner;
    localparam int W  = 8;
    localparam int DB = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] sw_raw;
    logic [W-1:0] switches;
    logic         sw_changed;
    logic         sw_stable;

    int n_checks = 0;
    int n_fail   = 0;

    switch_conditioner #(.WIDTH(W), .DB_CYCLES(DB)) dut (
        .clk        (clk),
        .rst        (rst),
        .sw_raw     (sw_raw),
        .switches   (switches),
        .sw_changed (sw_changed),
        .sw_stable  (sw_stable)
    );

    always #5 clk = ~clk;

    // Reference model: hist[n-1] is the synchronized level seen at edge n (two
    // reset-level entries precede the first raw sample). A bit flips when the last
    // DB edges since its previous flip all saw a level differing from the output.
    logic [W-1:0] hist[$];
    logic [W-1:0] m_out    = '0;
    logic         m_chg    = 1'b0;
    logic         m_stable = 1'b1;
    int           lu[W];
    int           n_edge   = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist.delete();
            hist.push_back('0);
            hist.push_back('0);
            m_out    = '0;
            m_chg    = 1'b0;
            m_stable = 1'b1;
            n_edge   = 0;
            foreach (lu[b]) lu[b] = 0;
        end else begin
            logic [W-1:0] upd;
            logic         all0;
            int           run;
            int           k;
            n_edge++;
            hist.push_back(sw_raw);
            upd  = '0;
            all0 = 1'b1;
            for (int b = 0; b < W; b++) begin
                run = 0;
                k   = n_edge;
                while (k > lu[b] && hist[k-1][b] != m_out[b]) begin
                    run++;
                    k--;
                end
                if (run == DB) begin
                    upd[b] = 1'b1;
                    lu[b]  = n_edge;
                end else if (run != 0) begin
                    all0 = 1'b0;
                end
            end
            m_out    = m_out ^ upd;
            m_chg    = |upd;
            m_stable = all0;
        end
    end

    task automatic test_reset();
        rst    = 1'b0;
        sw_raw = 8'hFF;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({switches, sw_changed, sw_stable} !== {8'h00, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: got sw=%h chg=%b stb=%b, expected sw=00 chg=0 stb=1",
                     switches, sw_changed, sw_stable);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            logic [W-1:0] exp_sw;
            logic         exp_chg;
            @(negedge clk);
            exp_sw  = (e >= 6) ? 8'hFF : 8'h00;
            exp_chg = (e == 6);
            n_checks++;
            if (switches !== exp_sw || sw_changed !== exp_chg) begin
                n_fail++;
                $display("FAIL reset_release edge %0d: got sw=%h chg=%b, expected sw=%h chg=%b",
                         e, switches, sw_changed, exp_sw, exp_chg);
            end
            n_checks++;
            if ({switches, sw_changed, sw_stable} !== {m_out, m_chg, m_stable}) begin
                n_fail++;
                $display("FAIL reset_model edge %0d: got %h/%b/%b, expected %h/%b/%b",
                         e, switches, sw_changed, sw_stable, m_out, m_chg, m_stable);
            end
        end
    endtask

    task automatic test_step();
        int pulses;
        sw_raw = 8'h00;
        repeat (DB + 4) @(negedge clk);
        n_checks++;
        if (switches !== 8'h00 || sw_stable !== 1'b1) begin
            n_fail++;
            $display("FAIL step_settle: got sw=%h stb=%b, expected sw=00 stb=1", switches, sw_stable);
        end
        sw_raw = 8'h03;
        pulses = 0;
        for (int j = 0; j <= 8; j++) begin
            logic [W-1:0] exp_sw;
            logic         exp_stb;
            @(negedge clk);
            exp_sw  = (j >= 5) ? 8'h03 : 8'h00;
            exp_stb = !(j >= 2 && j <= 4);
            if (sw_changed === 1'b1) pulses++;
            n_checks++;
            if (switches !== exp_sw || sw_stable !== exp_stb) begin
                n_fail++;
                $display("FAIL step edge k+%0d: got sw=%h stb=%b, expected sw=%h stb=%b",
                         j, switches, sw_stable, exp_sw, exp_stb);
            end
            n_checks++;
            if ({switches, sw_changed, sw_stable} !== {m_out, m_chg, m_stable}) begin
                n_fail++;
                $display("FAIL step_model k+%0d: got %h/%b/%b, expected %h/%b/%b",
                         j, switches, sw_changed, sw_stable, m_out, m_chg, m_stable);
            end
        end
        n_checks++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL step_pulses: got %0d sw_changed pulses, expected 1", pulses);
        end
    endtask

    task automatic test_glitch();
        int pulses;
        sw_raw = 8'h00;
        repeat (DB + 4) @(negedge clk);
        sw_raw = 8'h01;
        pulses = 0;
        repeat (2) @(negedge clk);
        sw_raw = 8'h00;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (sw_changed === 1'b1) pulses++;
            n_checks++;
            if (switches[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL glitch cycle %0d: got switches[0]=%b, expected 0", j, switches[0]);
            end
        end
        n_checks++;
        if (pulses != 0 || sw_stable !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_end: got %0d pulses stb=%b, expected 0 pulses stb=1", pulses, sw_stable);
        end
    endtask

    task automatic test_bounce();
        logic lvl;
        lvl = 1'b1;
        for (int p = 0; p < 4; p++) begin
            sw_raw[7] = lvl;
            lvl       = ~lvl;
            repeat (2) begin
                @(negedge clk);
                n_checks++;
                if (switches[7] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bounce phase %0d: got switches[7]=%b, expected 0", p, switches[7]);
                end
            end
        end
        sw_raw[7] = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            n_checks++;
            if (switches[7] !== (e >= 6)) begin
                n_fail++;
                $display("FAIL bounce_final edge %0d: got switches[7]=%b, expected %b",
                         e, switches[7], (e >= 6));
            end
            n_checks++;
            if ({switches, sw_changed, sw_stable} !== {m_out, m_chg, m_stable}) begin
                n_fail++;
                $display("FAIL bounce_model edge %0d: got %h/%b/%b, expected %h/%b/%b",
                         e, switches, sw_changed, sw_stable, m_out, m_chg, m_stable);
            end
        end
    endtask

    task automatic test_midreset();
        sw_raw = 8'h00;
        repeat (DB + 4) @(negedge clk);
        sw_raw = 8'h80;
        repeat (3) @(negedge clk);
        n_checks++;
        if (sw_stable !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_counting: got stb=%b, expected 0", sw_stable);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (switches !== 8'h00 || sw_stable !== 1'b1 || sw_changed !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_clear: got sw=%h stb=%b chg=%b, expected 00/1/0",
                     switches, sw_stable, sw_changed);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            logic [W-1:0] exp_sw;
            @(negedge clk);
            exp_sw = (e >= 6) ? 8'h80 : 8'h00;
            n_checks++;
            if (switches !== exp_sw) begin
                n_fail++;
                $display("FAIL midreset_release edge %0d: got sw=%h, expected %h", e, switches, exp_sw);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 80; it++) begin
            int hold;
            if (it % 3 == 0) sw_raw = W'($urandom);
            else             sw_raw = sw_raw ^ (W'($urandom) & W'($urandom));
            hold = (it % 2 == 0) ? $urandom_range(1, 3) : $urandom_range(DB, 2 * DB + 2);
            if (it == 40) begin
                rst = 1'b0;
                #1;
                n_checks++;
                if ({switches, sw_changed, sw_stable} !== {8'h00, 1'b0, 1'b1}) begin
                    n_fail++;
                    $display("FAIL random_reset: got %h/%b/%b, expected 00/0/1",
                             switches, sw_changed, sw_stable);
                end
                @(negedge clk);
                rst = 1'b1;
            end
            repeat (hold) begin
                @(negedge clk);
                n_checks++;
                if ({switches, sw_changed, sw_stable} !== {m_out, m_chg, m_stable}) begin
                    n_fail++;
                    $display("FAIL random it %0d raw=%h: got %h/%b/%b, expected %h/%b/%b",
                             it, sw_raw, switches, sw_changed, sw_stable, m_out, m_chg, m_stable);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_step();
        test_glitch();
        test_bounce();
        test_midreset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/switch_conditioner.md
SWITCH_CONDITIONER -- requirements
Module: switch_conditioner

Interface
REQ-001 Parameter: WIDTH, default 8, number of switch bits conditioned.
REQ-002 Parameter: DB_CYCLES, default 16, consecutive clk cycles a synchronized input must differ from the output before the output updates; legal range 2..65535.
REQ-003 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-low reset; rst=0 resets immediately, independent of clk.
REQ-005 Port: sw_raw  input  WIDTH  raw, asynchronous board switch levels.
REQ-006 Port: switches  output  WIDTH  debounced, synchronous switch levels; drives the processor top's switches input.
REQ-007 Port: sw_changed  output  1  one-cycle pulse; high in the cycle after any switches bit updated.
REQ-008 Port: sw_stable  output  1  high when every bit's debounce counter is zero.

Function
REQ-009 Each bit SHALL pass through a two-flop synchronizer, s1 then s2, before any other logic uses it.
REQ-010 Each bit SHALL own an independent counter, ceil(log2(DB_CYCLES)) bits wide, saturating at DB_CYCLES-1.
REQ-011 Per bit, per rising edge, one of three updates SHALL apply:
- s2 == switches[i]: cnt <= 0.
- s2 != switches[i] and cnt < DB_CYCLES-1: cnt <= cnt+1.
- s2 != switches[i] and cnt == DB_CYCLES-1: switches[i] <= s2, cnt <= 0.
REQ-012 Latency: a sw_raw change held stable from before edge k SHALL appear on switches at edge k+1+DB_CYCLES, with no earlier change.
REQ-013 A raw pulse whose synchronized image lasts fewer than DB_CYCLES cycles SHALL leave switches unchanged; the counter clears on return.
REQ-014 Bouncing input SHALL restart the count from 0 at each return to the output level; only an uninterrupted DB_CYCLES-cycle difference updates the bit.
REQ-015 Bits SHALL be independent; several bits changing simultaneously SHALL each update at their own qualifying edge, possibly the same edge.
REQ-016 sw_changed SHALL be registered and set high at any edge where at least one bit of switches updates, and low otherwise; simultaneous bit updates produce a single pulse.
REQ-017 sw_stable SHALL be combinational from the counters: high iff all counters are 0.
REQ-018 No combinational path SHALL exist from sw_raw to any output.

Reset
REQ-019 While rst=0, s1, s2, all counters, switches, and sw_changed SHALL be 0; sw_stable SHALL be 1.
REQ-020 Reset asserted mid-count SHALL discard partial counts; after release, debouncing restarts from the reset state.
REQ-021 After rst rises, the first state update SHALL occur at the next rising clk edge; a sw_raw value held through reset takes DB_CYCLES+2 edges to reach switches.

Verification (DB_CYCLES=4, clk period 10 ns)
REQ-022 Reset: rst=0 for 40 ns with sw_raw=8'hFF -> switches=8'h00, sw_changed=0, sw_stable=1; after release, switches=8'hFF at the 6th rising edge, with sw_changed=1 for exactly the following cycle.
REQ-023 Step: switches=8'h00, sw_raw set to 8'h03 before edge k -> switches=8'h03 at edge k+5, one sw_changed pulse, sw_stable=0 during edges k+2..k+4.
REQ-024 Glitch: sw_raw[0] high for 2 cycles, then low -> switches[0] stays 0, sw_changed never asserts, sw_stable returns to 1.
REQ-025 Bounce: sw_raw[7] toggles 1,0,1,0,1, each level held 2 cycles, then stays 1 -> switches[7] rises exactly 6 edges after the final 0->1 transition, not before.
REQ-026 Mid-count reset: sw_raw=8'h80 and rst driven low at the 3rd edge after the change -> switches stays 8'h00, counters cleared; after release, switches=8'h80 after 6 further edges.
